// File: rtl/alu_traffic_checker.sv
// Self-checking traffic source for a valid/ready ALU: LFSR-driven command issue,
// in-order expected-result FIFO, result scoreboard and idle-progress timeout.
module alu_traffic_checker #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [15:0]      i_count,
    input  logic [31:0]      i_seed,
    input  logic             i_alu_ready,
    input  logic             i_alu_res_valid,
    input  logic [WIDTH-1:0] i_alu_result,
    output logic [WIDTH-1:0] o_alu_a,
    output logic [WIDTH-1:0] o_alu_b,
    output logic [1:0]       o_alu_op,
    output logic             o_alu_req,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_timeout,
    output logic [15:0]      o_pass_cnt,
    output logic [15:0]      o_fail_cnt,
    output logic [15:0]      o_first_fail_idx
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state, state_n;
    logic [31:0]       lfsr, lfsr_n, lfsr_b;
    logic [15:0]       issued, issued_n, total, total_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [TW-1:0]     tcnt;
    logic [WIDTH-1:0]  fifo_res [DEPTH];
    logic [15:0]       fifo_idx [DEPTH];
    logic              start, busy, xfer, pop, tmo_hit, req_n;

    function automatic logic [31:0] step(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic logic [WIDTH-1:0] alu_ref(input logic [WIDTH-1:0] a, b,
                                                  input logic [1:0] op);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a ^ b;
        endcase
    endfunction

    always_comb begin
        start   = i_start && (state == IDLE || state == DONE);
        busy    = (state == RUN) || (state == DRAIN);
        xfer    = o_alu_req && i_alu_ready;
        pop     = i_alu_res_valid && (cnt != '0);
        tmo_hit = busy && !xfer && !i_alu_res_valid && (tcnt == TW'(TIMEOUT - 1));

        state_n = state;
        case (state)
            IDLE, DONE: if (start) state_n = (i_count == 16'd0) ? DONE : RUN;
            RUN:        if (tmo_hit) state_n = DONE;
                        else if (issued == total) state_n = DRAIN;
            DRAIN:      if (tmo_hit || cnt == '0) state_n = DONE;
        endcase

        total_n  = start ? i_count : total;
        issued_n = start ? 16'd0 : issued + 16'(xfer);
        if (start)     lfsr_n = (i_seed == 32'd0) ? 32'd1 : i_seed;
        else if (xfer) lfsr_n = step(step(lfsr));
        else           lfsr_n = lfsr;
        lfsr_b = step(lfsr_n);
        // A timeout abandons everything still in flight, so the FIFO is flushed with it.
        cnt_n  = (start || tmo_hit) ? '0 : cnt + CW'(xfer) - CW'(pop);
        req_n  = (state_n == RUN) && (issued_n < total_n) && (cnt_n < CW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (xfer) begin
            fifo_res[wr_ptr] <= alu_ref(o_alu_a, o_alu_b, o_alu_op);
            fifo_idx[wr_ptr] <= issued;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            lfsr             <= 32'd1;
            issued           <= '0;
            total            <= '0;
            cnt              <= '0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            tcnt             <= '0;
            o_alu_req        <= 1'b0;
            o_alu_a          <= '0;
            o_alu_b          <= '0;
            o_alu_op         <= '0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
            o_timeout        <= 1'b0;
            o_pass_cnt       <= '0;
            o_fail_cnt       <= '0;
            o_first_fail_idx <= 16'hFFFF;
        end else begin
            state     <= state_n;
            lfsr      <= lfsr_n;
            issued    <= issued_n;
            total     <= total_n;
            cnt       <= cnt_n;
            o_alu_req <= req_n;
            o_busy    <= (state_n == RUN) || (state_n == DRAIN);
            o_done    <= (state_n == DONE);
            // Operands track the next LFSR value, so they stay put while ready is low.
            if (state_n == RUN) begin
                o_alu_a  <= lfsr_n[WIDTH-1:0];
                o_alu_b  <= lfsr_b[WIDTH-1:0];
                o_alu_op <= issued_n[1:0];
            end

            if (start || tmo_hit) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (xfer) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end

            if (start || !busy || xfer || i_alu_res_valid || tmo_hit) tcnt <= '0;
            else                                                     tcnt <= tcnt + 1'b1;

            if (start)        o_timeout <= 1'b0;
            else if (tmo_hit) o_timeout <= 1'b1;

            if (start) begin
                o_pass_cnt       <= '0;
                o_fail_cnt       <= '0;
                o_first_fail_idx <= 16'hFFFF;
            end else if (i_alu_res_valid) begin
                if (pop && fifo_res[rd_ptr] == i_alu_result) begin
                    if (o_pass_cnt != 16'hFFFF) o_pass_cnt <= o_pass_cnt + 16'd1;
                end else begin
                    if (o_fail_cnt != 16'hFFFF) o_fail_cnt <= o_fail_cnt + 16'd1;
                    if (pop && o_first_fail_idx == 16'hFFFF)
                        o_first_fail_idx <= fifo_idx[rd_ptr];
                end
            end
        end
    end

endmodule
